// File: rtl/ice_msgbuf_pkg.sv
// ice_msgbuf shared definitions: write-FSM states, word layout and a word-packing helper.
package ice_msgbuf_pkg;

   localparam int WORD_W       = 9;
   localparam int END_FLAG_BIT = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
      ST_COMMIT = 2'd2,
      ST_DROP   = 2'd3
   } wr_state_t;

   // Pack a stored word: bit 8 flags the final byte of a frame.
   function automatic logic [WORD_W-1:0] make_word(input logic end_flag, input logic [7:0] data);
      return {end_flag, data};
   endfunction

endpackage

// File: rtl/ice_msgbuf_chk.sv
// ice_msgbuf_chk: simulation checker for controller-side protocol on an ice_msgbuf port.
module ice_msgbuf_chk (
   input logic clk,
   input logic rst,
   input logic sl_latch_tail,
   input logic sl_arb_request
);

   // The buffer ignores a tail latch while no frame is stored; flag it as a controller bug.
   property p_no_latch_when_empty;
      @(posedge clk) disable iff (rst) sl_latch_tail |-> sl_arb_request;
   endproperty

   a_no_latch_when_empty: assert property (p_no_latch_when_empty)
      else $error("ice_msgbuf_chk: tail latched with no stored frame");

endmodule

// File: rtl/ice_msgbuf_ram.sv
// ice_msgbuf_ram: simple dual-port 2^ADDR_WIDTH x 9 RAM, synchronous write, registered read.
// The read register is reset so the controller-facing data word starts at zero.
module ice_msgbuf_ram
   import ice_msgbuf_pkg::*;
#(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WORD_W-1:0]     wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WORD_W-1:0]     rd_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [WORD_W-1:0] mem_r [0:DEPTH-1];
   logic [WORD_W-1:0] rd_data_r;

   // Storage array write port; contents are not cleared by reset (pointers define validity).
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port, one cycle after the address is presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_r <= {WORD_W{1'b0}};
      end else begin
         rd_data_r <= mem_r[rd_addr];
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/ice_msgbuf.sv
// ice_msgbuf: per-slot framed message buffer for the ICE bus controller transmit path.
// Bytes are written one behind the producer through a holding register so the last
// byte of a frame can be flagged. Frames that do not fit are discarded whole.
// Optional build macro ICE_MSGBUF_STATS_EN enables the saturating dropped-frame counter;
// without it drop_count is tied to zero.
module ice_msgbuf
   import ice_msgbuf_pkg::*;
#(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_data_valid,
   input  logic                  in_frame_valid,
   output logic                  drop_pulse,
   output logic [7:0]            drop_count,
   input  logic [ADDR_WIDTH-1:0] sl_addr,
   output logic [WORD_W-1:0]     sl_data,
   output logic [ADDR_WIDTH-1:0] sl_tail,
   input  logic                  sl_latch_tail,
   output logic                  sl_arb_request,
   input  logic                  sl_arb_grant
);

   localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   wr_state_t             state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0] tail_r, head_r, wr_ptr_r, frame_count_r;
   logic [ADDR_WIDTH-1:0] tail_nxt_s, head_nxt_s, wr_ptr_nxt_s, frame_count_nxt_s;
   logic [7:0]            pend_byte_r, pend_byte_nxt_s;
   logic                  pend_valid_r, pend_valid_nxt_s;
   logic                  arb_req_r, drop_pulse_r;
   logic [ADDR_WIDTH-1:0] free_s;
   logic                  full_s, commit_s, enter_drop_s, latch_ok_s;
   logic                  ram_we_s;
   logic [WORD_W-1:0]     ram_wdata_s;
   logic                  unused_s;

   // Grant is informational only; it never affects buffer state.
   assign unused_s = sl_arb_grant;

   // One slot is always kept empty so tail == wr_ptr unambiguously means empty.
   assign free_s     = tail_r - wr_ptr_r - PTR_ONE;
   assign full_s     = (free_s == PTR_ZERO);
   assign latch_ok_s = sl_latch_tail && (frame_count_r != PTR_ZERO);

   // Write FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Write FSM next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_frame_valid) begin
               state_nxt_s = ST_WRITE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (!in_frame_valid) begin
               if (pend_valid_r) begin
                  state_nxt_s = ST_COMMIT;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else if (in_data_valid && pend_valid_r && full_s) begin
               state_nxt_s = ST_DROP;
            end else begin
               state_nxt_s = ST_WRITE;
            end
         end
         ST_COMMIT: begin
            if (full_s) begin
               state_nxt_s = ST_DROP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (!in_frame_valid) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DROP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Write FSM datapath actions: RAM writes, pointer moves and holding-register updates.
   always_comb begin
      ram_we_s         = 1'b0;
      ram_wdata_s      = {WORD_W{1'b0}};
      wr_ptr_nxt_s     = wr_ptr_r;
      head_nxt_s       = head_r;
      pend_byte_nxt_s  = pend_byte_r;
      pend_valid_nxt_s = pend_valid_r;
      commit_s         = 1'b0;
      enter_drop_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (in_frame_valid) begin
               pend_valid_nxt_s = in_data_valid;
               if (in_data_valid) begin
                  pend_byte_nxt_s = in_data;
               end else begin
                  pend_byte_nxt_s = pend_byte_r;
               end
            end else begin
               pend_valid_nxt_s = 1'b0;
            end
         end
         ST_WRITE: begin
            if (in_frame_valid && in_data_valid) begin
               if (!pend_valid_r) begin
                  pend_byte_nxt_s  = in_data;
                  pend_valid_nxt_s = 1'b1;
               end else if (full_s) begin
                  // Roll back to the last committed frame end.
                  enter_drop_s     = 1'b1;
                  wr_ptr_nxt_s     = head_r;
                  pend_valid_nxt_s = 1'b0;
               end else begin
                  ram_we_s        = 1'b1;
                  ram_wdata_s     = make_word(1'b0, pend_byte_r);
                  wr_ptr_nxt_s    = wr_ptr_r + PTR_ONE;
                  pend_byte_nxt_s = in_data;
               end
            end else begin
               pend_byte_nxt_s = pend_byte_r;
            end
         end
         ST_COMMIT: begin
            if (full_s) begin
               enter_drop_s     = 1'b1;
               wr_ptr_nxt_s     = head_r;
               pend_valid_nxt_s = 1'b0;
            end else begin
               ram_we_s         = 1'b1;
               ram_wdata_s      = make_word(1'b1, pend_byte_r);
               wr_ptr_nxt_s     = wr_ptr_r + PTR_ONE;
               head_nxt_s       = wr_ptr_r + PTR_ONE;
               pend_valid_nxt_s = 1'b0;
               commit_s         = 1'b1;
            end
         end
         ST_DROP: begin
            pend_valid_nxt_s = 1'b0;
         end
         default: begin
            pend_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // Frame accounting and read-side tail; a commit and a latch together cancel out.
   always_comb begin
      case ({commit_s, latch_ok_s})
         2'b10:   frame_count_nxt_s = frame_count_r + PTR_ONE;
         2'b01:   frame_count_nxt_s = frame_count_r - PTR_ONE;
         default: frame_count_nxt_s = frame_count_r;
      endcase
      if (latch_ok_s) begin
         tail_nxt_s = sl_addr;
      end else begin
         tail_nxt_s = tail_r;
      end
   end

   // Pointer, holding-register and registered-output state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tail_r        <= PTR_ZERO;
         head_r        <= PTR_ZERO;
         wr_ptr_r      <= PTR_ZERO;
         frame_count_r <= PTR_ZERO;
         pend_byte_r   <= 8'd0;
         pend_valid_r  <= 1'b0;
         arb_req_r     <= 1'b0;
         drop_pulse_r  <= 1'b0;
      end else begin
         tail_r        <= tail_nxt_s;
         head_r        <= head_nxt_s;
         wr_ptr_r      <= wr_ptr_nxt_s;
         frame_count_r <= frame_count_nxt_s;
         pend_byte_r   <= pend_byte_nxt_s;
         pend_valid_r  <= pend_valid_nxt_s;
         arb_req_r     <= (frame_count_nxt_s != PTR_ZERO);
         drop_pulse_r  <= enter_drop_s;
      end
   end

`ifdef ICE_MSGBUF_STATS_EN
   logic [7:0] drop_count_r;

   // Saturating dropped-frame counter, advanced together with drop_pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_count_r <= 8'd0;
      end else if (enter_drop_s && (drop_count_r != 8'hFF)) begin
         drop_count_r <= drop_count_r + 8'd1;
      end else begin
         drop_count_r <= drop_count_r;
      end
   end

   assign drop_count = drop_count_r;
`else
   assign drop_count = 8'd0;
`endif

   assign drop_pulse     = drop_pulse_r;
   assign sl_tail        = tail_r;
   assign sl_arb_request = arb_req_r;

   ice_msgbuf_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ram_we_s),
      .wr_addr (wr_ptr_r),
      .wr_data (ram_wdata_s),
      .rd_addr (sl_addr),
      .rd_data (sl_data)
   );

endmodule

// File: tb/tb_ice_msgbuf.sv
// tb_ice_msgbuf: directed scoreboard bench for ice_msgbuf.
module tb_ice_msgbuf;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'd0;
   logic       in_data_valid = 1'b0;
   logic       in_frame_valid = 1'b0;
   logic       drop_pulse;
   logic [7:0] drop_count;
   logic [8:0] sl_addr = 9'd0;
   logic [8:0] sl_data;
   logic [8:0] sl_tail;
   logic       sl_latch_tail = 1'b0;
   logic       sl_arb_request;
   logic       sl_arb_grant = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [17:0] rd_q[$];
   logic [7:0]  drop_q[$];
   logic        rd_issue = 1'b0;
   logic        rd_stb_d = 1'b0;
   logic [17:0] mon_ent;
   logic [7:0]  mon_drop;
   logic [7:0]  fb [0:511];
   logic [7:0]  exp_drop_cnt;

   always #5 clk = ~clk;

   ice_msgbuf #(.ADDR_WIDTH(9)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_data        (in_data),
      .in_data_valid  (in_data_valid),
      .in_frame_valid (in_frame_valid),
      .drop_pulse     (drop_pulse),
      .drop_count     (drop_count),
      .sl_addr        (sl_addr),
      .sl_data        (sl_data),
      .sl_tail        (sl_tail),
      .sl_latch_tail  (sl_latch_tail),
      .sl_arb_request (sl_arb_request),
      .sl_arb_grant   (sl_arb_grant)
   );

   ice_msgbuf_chk u_chk (
      .clk            (clk),
      .rst            (rst),
      .sl_latch_tail  (sl_latch_tail),
      .sl_arb_request (sl_arb_request)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Read strobe delayed to the cycle sl_data reflects the issued address.
   always @(posedge clk) rd_stb_d <= rd_issue;

   // Monitor: pops expected words and drop events whenever the DUT presents them.
   always @(negedge clk) begin
      if (rd_stb_d) begin
         if (rd_q.size() == 0) begin
            n_checks++;
            $display("FAIL rd_unexpected: got sl_data 0x%0h with no expected entry", sl_data);
         end else begin
            mon_ent = rd_q.pop_front();
            check($sformatf("rd_data@%0d", mon_ent[17:9]), 32'(sl_data), 32'(mon_ent[8:0]));
         end
      end
      if (drop_pulse && !rst) begin
         if (drop_q.size() == 0) begin
            n_checks++;
            $display("FAIL drop_unexpected: got drop_pulse=1, expected 0");
         end else begin
            mon_drop = drop_q.pop_front();
            check("drop_count_at_pulse", 32'(drop_count), 32'(mon_drop));
         end
      end
   end

   task automatic rd(input logic [8:0] a, input logic [8:0] exp);
      @(negedge clk);
      sl_addr  = a;
      rd_issue = 1'b1;
      rd_q.push_back({a, exp});
   endtask

   task automatic rd_end();
      @(negedge clk);
      rd_issue = 1'b0;
      @(negedge clk);
   endtask

   task automatic latch(input logic [8:0] a, input logic exp_req);
      @(negedge clk);
      sl_addr       = a;
      sl_latch_tail = 1'b1;
      @(posedge clk);
      #1;
      check("latch_tail", 32'(sl_tail), 32'(a));
      check("latch_req", 32'(sl_arb_request), 32'(exp_req));
      @(negedge clk);
      sl_latch_tail = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic exp_e1, input logic exp_e2,
                             input logic do_latch, input logic [8:0] latch_addr);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_frame_valid = 1'b1;
         in_data_valid  = 1'b1;
         in_data        = fb[i];
      end
      @(negedge clk);
      in_frame_valid = 1'b0;
      in_data_valid  = 1'b0;
      in_data        = 8'd0;
      @(posedge clk);
      #1;
      check("req_after_end_edge", 32'(sl_arb_request), 32'(exp_e1));
      if (do_latch) begin
         @(negedge clk);
         sl_addr       = latch_addr;
         sl_latch_tail = 1'b1;
      end
      @(posedge clk);
      #1;
      check("req_after_commit_edge", 32'(sl_arb_request), 32'(exp_e2));
      if (do_latch) begin
         check("tail_at_commit_latch", 32'(sl_tail), 32'(latch_addr));
         @(negedge clk);
         sl_latch_tail = 1'b0;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef ICE_MSGBUF_STATS_EN
      exp_drop_cnt = 8'd1;
`else
      exp_drop_cnt = 8'd0;
`endif
      // Reset values
      @(negedge clk);
      @(negedge clk);
      check("rst_sl_data", 32'(sl_data), 32'd0);
      check("rst_sl_tail", 32'(sl_tail), 32'd0);
      check("rst_req", 32'(sl_arb_request), 32'd0);
      check("rst_drop_pulse", 32'(drop_pulse), 32'd0);
      check("rst_drop_count", 32'(drop_count), 32'd0);
      rst = 1'b0;

      // Single frame at 0..3, request two cycles after frame end
      fb[0] = 8'h10; fb[1] = 8'h22; fb[2] = 8'h03; fb[3] = 8'hAA;
      send_frame(4, 1'b0, 1'b1, 1'b0, 9'd0);
      rd(9'd0, 9'h010); rd(9'd1, 9'h022); rd(9'd2, 9'h003); rd(9'd3, 9'h1AA);
      rd_end();
      latch(9'd4, 1'b0);

      // Two back-to-back frames at 4..5 and 6
      fb[0] = 8'h01; fb[1] = 8'h02;
      send_frame(2, 1'b0, 1'b1, 1'b0, 9'd0);
      fb[0] = 8'h03;
      send_frame(1, 1'b1, 1'b1, 1'b0, 9'd0);
      rd(9'd4, 9'h001); rd(9'd5, 9'h102); rd(9'd6, 9'h103);
      rd_end();
      latch(9'd6, 1'b1);
      latch(9'd7, 1'b0);

      // Commit coincides with a latch while one frame is stored
      fb[0] = 8'h44; fb[1] = 8'h55;
      send_frame(2, 1'b0, 1'b1, 1'b0, 9'd0);
      fb[0] = 8'h66;
      send_frame(1, 1'b1, 1'b1, 1'b1, 9'd9);
      rd(9'd7, 9'h044); rd(9'd8, 9'h155); rd(9'd9, 9'h166);
      rd_end();
      latch(9'd10, 1'b0);

      // Advance pointers to 510 with a long frame
      for (int i = 0; i < 500; i++) fb[i] = 8'(i);
      send_frame(500, 1'b0, 1'b1, 1'b0, 9'd0);
      rd(9'd10, 9'h000); rd(9'd509, 9'h1F3);
      rd_end();
      latch(9'd510, 1'b0);

      // Wrap-around frame at 510, 511, 0, 1; next frame lands at 2
      sl_arb_grant = 1'b1;
      fb[0] = 8'hA1; fb[1] = 8'hA2; fb[2] = 8'hA3; fb[3] = 8'hA4;
      send_frame(4, 1'b0, 1'b1, 1'b0, 9'd0);
      fb[0] = 8'h77;
      send_frame(1, 1'b1, 1'b1, 1'b0, 9'd0);
      rd(9'd510, 9'h0A1); rd(9'd511, 9'h0A2); rd(9'd0, 9'h0A3); rd(9'd1, 9'h1A4); rd(9'd2, 9'h177);
      rd_end();
      sl_arb_grant = 1'b0;
      latch(9'd2, 1'b1);
      latch(9'd3, 1'b0);

      // Reset in the middle of a frame
      @(negedge clk);
      in_frame_valid = 1'b1; in_data_valid = 1'b1; in_data = 8'h31;
      @(negedge clk);
      in_data = 8'h32;
      @(negedge clk);
      rst = 1'b1;
      in_frame_valid = 1'b0; in_data_valid = 1'b0; in_data = 8'd0;
      #1;
      check("midrst_sl_data", 32'(sl_data), 32'd0);
      check("midrst_sl_tail", 32'(sl_tail), 32'd0);
      check("midrst_req", 32'(sl_arb_request), 32'd0);
      check("midrst_drop_pulse", 32'(drop_pulse), 32'd0);
      check("midrst_drop_count", 32'(drop_count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      fb[0] = 8'h5A; fb[1] = 8'h5B;
      send_frame(2, 1'b0, 1'b1, 1'b0, 9'd0);
      rd(9'd0, 9'h05A); rd(9'd1, 9'h15B);
      rd_end();

      // Fill to 511 words with tail at 0, then a frame that cannot fit
      for (int i = 0; i < 509; i++) fb[i] = 8'(i);
      send_frame(509, 1'b1, 1'b1, 1'b0, 9'd0);
      drop_q.push_back(exp_drop_cnt);
      fb[0] = 8'hD1; fb[1] = 8'hD2; fb[2] = 8'hD3;
      send_frame(3, 1'b1, 1'b1, 1'b0, 9'd0);
      check("drop_count_after", 32'(drop_count), 32'(exp_drop_cnt));
      check("drop_pulse_idle", 32'(drop_pulse), 32'd0);
      rd(9'd510, 9'h1FC);
      rd_end();
      // Free the first frame; the next frame must land at the unchanged head (511)
      latch(9'd2, 1'b1);
      fb[0] = 8'h99;
      send_frame(1, 1'b1, 1'b1, 1'b0, 9'd0);
      rd(9'd511, 9'h199); rd(9'd2, 9'h000);
      rd_end();
      latch(9'd511, 1'b1);
      latch(9'd0, 1'b0);

      repeat (4) @(negedge clk);
      check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
      check("drop_queue_drained", 32'(drop_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
